// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush/redirect controller for the 5-stage RV32I core
//
// Purpose: resolves load-use hazards, EX-resolved taken branches/jumps and
// data-memory wait states (with a sticky watchdog). The response for each cycle
// is combinational (zero latency), and the priority is freeze > jump > load-use.
//
// Optional feature: define PIPE_PERF_CNT_EN to instantiate the stall/flush
// performance counters. When it is undefined, both counter outputs are tied to 0.
//
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   id_rs1_i/id_rs2_i     source register indices of the instruction in ID
//   id_rs1_en_i/_rs2_en_i the ID instruction really reads that source
//   ex_rd_i, ex_is_load_i destination and load flag of the instruction in EX
//   ex_jump_i             taken branch / JAL / JALR in EX
//   ex_jump_addr_i        target of that jump
//   mem_req_i/mem_ready_i data access outstanding / completing this cycle
//   pc_hold_o, pc_redirect_o, pc_redirect_addr_o       PC controls
//   *_stall_o, *_flush_o  pipeline register controls
//   mem_timeout_o         sticky watchdog error flag
//   perf_stall_cnt_o      pc_hold cycles (optional feature)
//   perf_flush_cnt_o      redirect cycles (optional feature)

module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_rs1_en_i,
  input  logic        id_rs2_en_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_is_load_i,
  input  logic        ex_jump_i,
  input  logic [31:0] ex_jump_addr_i,
  input  logic        mem_req_i,
  input  logic        mem_ready_i,
  output logic        pc_hold_o,
  output logic        pc_redirect_o,
  output logic [31:0] pc_redirect_addr_o,
  output logic        if_id_stall_o,
  output logic        if_id_flush_o,
  output logic        id_ex_stall_o,
  output logic        id_ex_flush_o,
  output logic        ex_mem_stall_o,
  output logic        mem_wb_stall_o,
  output logic        mem_timeout_o,
  output logic [31:0] perf_stall_cnt_o,
  output logic [31:0] perf_flush_cnt_o
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_MEMW = 1'b1;

  localparam logic [TO_W-1:0] CNT_ONE  = TO_W'(1);
  localparam logic [TO_W-1:0] CNT_MAX  = TO_W'(MEM_TIMEOUT);
  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(MEM_TIMEOUT - 1);

  logic [0:0]      state, state_nxt;
  logic [TO_W-1:0] wait_cnt, wait_nxt;
  logic            timeout_q;

  logic freeze, jump, lu;

  assign freeze = mem_req_i & ~mem_ready_i;
  assign jump   = ex_jump_i;
  // x0 is never a real destination, so a load into x0 creates no dependency
  assign lu     = ex_is_load_i & (ex_rd_i != 5'd0) &
                  ((id_rs1_en_i & (id_rs1_i == ex_rd_i)) |
                   (id_rs2_en_i & (id_rs2_i == ex_rd_i)));

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    case (state)
      ST_RUN: begin
        if (freeze) begin
          state_nxt = ST_MEMW;
          wait_nxt  = CNT_ONE;
        end else begin
          state_nxt = ST_RUN;
          wait_nxt  = '0;
        end
      end
      ST_MEMW: begin
        if (freeze) begin
          state_nxt = ST_MEMW;
          wait_nxt  = (wait_cnt >= CNT_MAX) ? CNT_MAX : wait_cnt + CNT_ONE;
        end else begin
          state_nxt = ST_RUN;
          wait_nxt  = '0;
        end
      end
      default: begin
        state_nxt = ST_RUN;
        wait_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      // The first freeze cycle sees wait_cnt == 0, so this fires on the edge
      // that closes the MEM_TIMEOUT-th consecutive freeze cycle. It is sticky,
      // and it does not release the freeze.
      if (freeze && (wait_cnt == CNT_LAST)) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign mem_timeout_o = timeout_q;

  // Outputs are forced to their reset values while rst_n is low, so an
  // asynchronous reset in the middle of a wait drops the stalls immediately.
  always_comb begin
    pc_hold_o          = 1'b0;
    pc_redirect_o      = 1'b0;
    pc_redirect_addr_o = '0;
    if_id_stall_o      = 1'b0;
    if_id_flush_o      = 1'b0;
    id_ex_stall_o      = 1'b0;
    id_ex_flush_o      = 1'b0;
    ex_mem_stall_o     = 1'b0;
    mem_wb_stall_o     = 1'b0;
    if (rst_n) begin
      pc_redirect_addr_o = ex_jump_addr_i;
      if (freeze) begin
        // Whole pipe holds. A pending jump or load-use stays in the frozen
        // registers and is acted on in the cycle the access completes.
        pc_hold_o      = 1'b1;
        if_id_stall_o  = 1'b1;
        id_ex_stall_o  = 1'b1;
        ex_mem_stall_o = 1'b1;
        mem_wb_stall_o = 1'b1;
      end else if (jump) begin
        // The dependent instruction in ID is flushed, so any load-use is moot
        pc_redirect_o = 1'b1;
        if_id_flush_o = 1'b1;
        id_ex_flush_o = 1'b1;
      end else if (lu) begin
        // One bubble: the load reaches MEM next cycle and can be forwarded
        pc_hold_o     = 1'b1;
        if_id_stall_o = 1'b1;
        id_ex_flush_o = 1'b1;
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 32'(pc_hold_o);
      flush_cnt <= flush_cnt + 32'(pc_redirect_o);
    end
  end

  assign perf_stall_cnt_o = stall_cnt;
  assign perf_flush_cnt_o = flush_cnt;
`else
  assign perf_stall_cnt_o = '0;
  assign perf_flush_cnt_o = '0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV32I core.
- Sits beside the decoder/ALU-control unit and drives stall, flush and PC-redirect controls into the PC, if_id, id_ex, ex_mem and mem_wb registers.
- Resolves three event types:
  - Load-use hazards: ID operand depends on a load in EX.
  - Taken branches/jumps resolved in EX.
  - Data-memory wait states, with a watchdog timeout.

Parameters:
MEM_TIMEOUT, 16, consecutive freeze cycles after which mem_timeout_o is set (legal range 2..255)
TO_W, 8, width of the internal wait counter (must hold MEM_TIMEOUT)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_rs1_i  in  5  rs1 index of instruction in ID
id_rs2_i  in  5  rs2 index of instruction in ID
id_rs1_en_i  in  1  ID instruction reads rs1
id_rs2_en_i  in  1  ID instruction reads rs2
ex_rd_i  in  5  rd index of instruction in EX
ex_is_load_i  in  1  EX instruction is a load
ex_jump_i  in  1  EX branch taken / JAL / JALR
ex_jump_addr_i  in  32  target of taken branch/jump
mem_req_i  in  1  MEM stage has an outstanding data access
mem_ready_i  in  1  data memory completes access this cycle
pc_hold_o  out  1  PC keeps its value
pc_redirect_o  out  1  PC loads pc_redirect_addr_o
pc_redirect_addr_o  out  32  redirect target
if_id_stall_o  out  1  hold if_id register
if_id_flush_o  out  1  load NOP into if_id
id_ex_stall_o  out  1  hold id_ex register
id_ex_flush_o  out  1  load bubble (reg_we=0, ALU NO_OP) into id_ex
ex_mem_stall_o  out  1  hold ex_mem register
mem_wb_stall_o  out  1  hold mem_wb register
mem_timeout_o  out  1  sticky watchdog error flag
perf_stall_cnt_o  out  32  stall-cycle counter (optional feature)
perf_flush_cnt_o  out  32  flush-event counter (optional feature)

Behaviour:
- Reset: all control outputs are 0, pc_redirect_addr_o is 0, and wait_cnt is 0. mem_timeout_o and both perf counters are 0. FSM enters RUN.
- Clock and reset: one clock domain. rst_n is asynchronous assert, synchronous deassert externally.
- Control outputs are combinational from the inputs and the registered state (zero-latency decision).

Events:
- freeze = mem_req_i & ~mem_ready_i.
- jump = ex_jump_i.
- lu = ex_is_load_i & (ex_rd_i != 0) & ((id_rs1_en_i & id_rs1_i == ex_rd_i) | (id_rs2_en_i & id_rs2_i == ex_rd_i)).

Priority (exactly one response per cycle): freeze > jump > lu.
- freeze:
  - pc_hold_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o and mem_wb_stall_o are all 1.
  - No flush, no redirect.
  - A pending jump/lu is held in the frozen regs and re-evaluated after release.
- jump:
  - pc_redirect_o = 1 and pc_redirect_addr_o = ex_jump_addr_i.
  - if_id_flush_o = 1 and id_ex_flush_o = 1.
  - pc_hold_o = 0. lu is ignored, since the dependent instruction is flushed.
- lu:
  - pc_hold_o = 1, if_id_stall_o = 1, id_ex_flush_o = 1.
  - Exactly 1 bubble, because the load advances to MEM next cycle.
- None of the above: all outputs 0. pc_redirect_addr_o = ex_jump_addr_i at all times; it is don't-care when pc_redirect_o = 0.

FSM (states RUN, MEMW; state register plus wait_cnt):
- RUN:
  - freeze → MEMW, with wait_cnt <= 1.
  - Otherwise stay in RUN, with wait_cnt = 0.
- MEMW:
  - freeze → stay in MEMW, with wait_cnt <= wait_cnt + 1, saturating at MEM_TIMEOUT.
  - ~freeze → RUN, with wait_cnt <= 0. The stalls drop in the same cycle that mem_ready_i = 1.
- Watchdog:
  - mem_timeout_o is set at the edge where freeze = 1 and wait_cnt == MEM_TIMEOUT-1, i.e. it is visible after MEM_TIMEOUT consecutive freeze cycles.
  - It stays set until reset.
  - The freeze is not released by the timeout.
- mem_req_i = 0 with mem_ready_i = 1 is legal and is no freeze.
- Reset mid-MEMW: all outputs return to reset values asynchronously.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- Defined:
  - perf_stall_cnt_o increments on every cycle with pc_hold_o = 1.
  - perf_flush_cnt_o increments on every cycle with pc_redirect_o = 1.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and reset to 0.
- Undefined: both outputs are tied to 0 and no counter flops are instantiated.

Test Plan:
- Load-use: ex_is_load_i = 1, ex_rd_i = 5, id_rs2_en_i = 1, id_rs2_i = 5 for 1 cycle → pc_hold_o = 1, if_id_stall_o = 1, id_ex_flush_o = 1 for exactly that cycle. Repeat with ex_rd_i = 0 → no stall.
- Taken branch: ex_jump_i = 1, ex_jump_addr_i = 0x0000_0100 → pc_redirect_o = 1, addr 0x100, if_id_flush_o = id_ex_flush_o = 1, pc_hold_o = 0. Repeat with lu also true → same result.
- Memory wait: mem_req_i = 1, mem_ready_i = 0 for 3 cycles, then ready → all five stall/hold outputs are 1 for 3 cycles and 0 in the ready cycle; FSM returns to RUN; mem_timeout_o stays 0.
- Freeze plus jump: freeze and ex_jump_i asserted together for 2 cycles, then ready → no redirect while frozen; redirect to the target in the ready cycle.
- Watchdog: MEM_TIMEOUT = 16, freeze held 20 cycles → mem_timeout_o rises after cycle 16 and stays high after release; clears only on rst_n = 0 (asynchronously, mid-cycle).
- With PIPE_PERF_CNT_EN: 1 lu cycle, 3 freeze cycles, 2 jumps → perf_stall_cnt_o = 4 and perf_flush_cnt_o = 2. Without the macro: both outputs read 0.
